// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC receive scheduler.
// Holds FSM encoding, priority level codes and parameter defaults.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [1:0] L0 = 2'd0;
    localparam logic [1:0] L1 = 2'd1;
    localparam logic [1:0] L2 = 2'd2;
    localparam logic [1:0] L3 = 2'd3;

    localparam int          STARVE_LIMIT_DEF = 4;
    localparam logic [15:0] TIMEOUT_DEF      = 16'd4095;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/mac_rx_sched_if.sv
// Grant/accept/done handshake between the RX scheduler and the frame decoder.
// master = scheduler side, slave = decoder side.
interface mac_rx_sched_if;

    logic       grant_valid;
    logic [1:0] grant_id;
    logic       dec_ready;
    logic       dec_ack;
    logic       dec_done;

    modport master (
        output grant_valid,
        output grant_id,
        input  dec_ready,
        input  dec_ack,
        input  dec_done
    );

    modport slave (
        input  grant_valid,
        input  grant_id,
        output dec_ready,
        output dec_ack,
        output dec_done
    );

endinterface

// File: rtl/mac_rx_sched_rr_pick4.sv
// Four-way round-robin picker: first set request at or after ptr, wrapping.
// Latency: combinational; no backpressure.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       vld,
    output logic [1:0] idx
);

    // Scan from the far end back towards ptr so the nearest request wins.
    always_comb begin
        vld = 1'b0;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                vld = 1'b1;
                idx = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/vec_sync_2ff.sv
// Two-flop synchroniser for a vector of independent quasi-static flags.
// Latency: 2 cycles; no backpressure.
module vec_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mac_rx_sched.sv
// Picks which PHY FIFO the decoder drains next (starvation > afull > half > frame).
// Latency: grant 1 cycle after eligible IDLE; grant held until dec_ack, busy until done/timeout.
module mac_rx_sched
    import mac_sched_pkg::*;
#(
    parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [15:0] TIMEOUT      = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            sched_en,
    input  logic [3:0]      frame_exist,
    input  logic [3:0]      fifo_half,
    input  logic [3:0]      fifo_afull,
    output logic            abort,
    output logic            busy,
    mac_rx_sched_if.master  dec_if
);

    localparam logic [2:0]  LIMIT    = 3'(STARVE_LIMIT);
    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

    logic [3:0] half_s;
    logic [3:0] afull_s;

    vec_sync_2ff #(.WIDTH(4)) u_sync_half (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (fifo_half),
        .q      (half_s)
    );

    vec_sync_2ff #(.WIDTH(4)) u_sync_afull (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (fifo_afull),
        .q      (afull_s)
    );

    state_t          state_q, state_d;
    logic            grant_vld_q, grant_vld_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic            abort_q, abort_d;
    logic            busy_q, busy_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [3:0][2:0] starve_q, starve_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;

    logic [3:0] lvl3_req;
    logic [1:0] sel_lvl;
    logic [3:0] sel_req;
    logic       pick_vld;
    logic [1:0] pick_idx;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            lvl3_req[p] = frame_exist[p] && (starve_q[p] == LIMIT);
        end
    end

    // Only the highest non-empty level competes; lower levels wait.
    always_comb begin
        if (|lvl3_req)       sel_lvl = L3;
        else if (|afull_s)   sel_lvl = L2;
        else if (|half_s)    sel_lvl = L1;
        else                 sel_lvl = L0;

        case (sel_lvl)
            L3:      sel_req = lvl3_req;
            L2:      sel_req = afull_s;
            L1:      sel_req = half_s;
            default: sel_req = frame_exist;
        endcase
    end

    rr_pick4 u_pick (
        .req (sel_req),
        .ptr (rr_ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_vld_d = grant_vld_q;
        grant_id_d  = grant_id_q;
        abort_d     = 1'b0;
        busy_d      = busy_q;
        rr_ptr_d    = rr_ptr_q;
        starve_d    = starve_q;
        tmo_cnt_d   = tmo_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sched_en && dec_if.dec_ready && pick_vld) begin
                    grant_id_d  = pick_idx;
                    grant_vld_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (dec_if.dec_ack) begin
                    grant_vld_d = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A frame finishing on the timeout cycle still counts as completed.
                if (dec_if.dec_done) begin
                    rr_ptr_d = ptr_inc(grant_id_q);
                    for (int p = 0; p < 4; p++) begin
                        if (2'(p) == grant_id_q)
                            starve_d[p] = '0;
                        else if (frame_exist[p])
                            starve_d[p] = (starve_q[p] >= LIMIT) ? LIMIT : starve_q[p] + 3'd1;
                        else
                            starve_d[p] = '0;
                    end
                    busy_d    = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    starve_d[grant_id_q] = '0;
                    abort_d   = 1'b1;
                    busy_d    = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: begin
                grant_vld_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            grant_vld_q <= 1'b0;
            grant_id_q  <= 2'd0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= 2'd0;
            starve_q    <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            starve_q    <= starve_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign dec_if.grant_valid = grant_vld_q;
    assign dec_if.grant_id    = grant_id_q;
    assign abort              = abort_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_mac_rx_sched.sv
// Directed scenarios plus randomized transactions against a transaction-level
// model of the priority/round-robin/starvation rules.
module tb_mac_rx_sched;

    localparam int          LIMIT = 4;
    localparam logic [15:0] TMO   = 16'd20;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       sched_en = 1'b0;
    logic [3:0] frame_exist = 4'd0;
    logic [3:0] fifo_half = 4'd0;
    logic [3:0] fifo_afull = 4'd0;
    logic       abort;
    logic       busy;

    mac_rx_sched_if bus ();

    mac_rx_sched #(
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TMO)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .sched_en    (sched_en),
        .frame_exist (frame_exist),
        .fifo_half   (fifo_half),
        .fifo_afull  (fifo_afull),
        .abort       (abort),
        .busy        (busy),
        .dec_if      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_rr = 0;
    int m_starve[4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Highest level with any eligible port wins; within it, first from m_rr upward.
    function automatic int model_pick(input logic [3:0] fe, input logic [3:0] h, input logic [3:0] af);
        int p;
        bit elig;
        for (int lvl = 3; lvl >= 0; lvl--) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                case (lvl)
                    3:       elig = fe[p] && (m_starve[p] == LIMIT);
                    2:       elig = af[p];
                    1:       elig = h[p];
                    default: elig = fe[p];
                endcase
                if (elig) return p;
            end
        end
        return -1;
    endfunction

    task automatic model_done(input int g, input logic [3:0] fe);
        for (int p = 0; p < 4; p++) begin
            if (p == g)     m_starve[p] = 0;
            else if (fe[p]) m_starve[p] = (m_starve[p] + 1 > LIMIT) ? LIMIT : m_starve[p] + 1;
            else            m_starve[p] = 0;
        end
        m_rr = (g + 1) % 4;
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int p = 0; p < 4; p++) m_starve[p] = 0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #2;
        chk("rst_grant_valid", 32'(bus.grant_valid), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_abort", 32'(abort), 0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        tick();
        arst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic set_flags(input logic [3:0] fe, input logic [3:0] h, input logic [3:0] af);
        frame_exist = fe;
        fifo_half   = h;
        fifo_afull  = af;
        repeat (3) tick();
    endtask

    // mode 0: done after short delay, 1: timeout, 2: done on the timeout cycle
    task automatic run_txn(input logic [3:0] fe, input logic [3:0] h, input logic [3:0] af,
                           input int want, input int mode, input bit chg_fe);
        int exp_id;
        int d;
        set_flags(fe, h, af);
        exp_id = model_pick(fe, h, af);
        sched_en = 1'b1;
        tick();
        if (exp_id < 0) begin
            repeat (2) tick();
            sched_en = 1'b0;
            chk("no_elig_grant_valid", 32'(bus.grant_valid), 0);
            chk("no_elig_busy", 32'(busy), 0);
        end else begin
            sched_en = 1'b0;
            chk("grant_valid", 32'(bus.grant_valid), 1);
            chk("grant_id", 32'(bus.grant_id), exp_id);
            if (want >= 0) chk("scenario_grant_id", 32'(bus.grant_id), want);
            chk("busy_in_grant", 32'(busy), 1);
            d = $urandom_range(0, 3);
            repeat (d) begin
                bus.dec_done = 1'($urandom_range(0, 1));
                fifo_half    = 4'($urandom);
                fifo_afull   = 4'($urandom);
                tick();
                chk("grant_hold_valid", 32'(bus.grant_valid), 1);
                chk("grant_hold_id", 32'(bus.grant_id), exp_id);
            end
            bus.dec_done = 1'b0;
            bus.dec_ack  = 1'b1;
            tick();
            bus.dec_ack  = 1'b0;
            chk("ack_drops_valid", 32'(bus.grant_valid), 0);
            chk("busy_after_ack", 32'(busy), 1);
            if (chg_fe) frame_exist = 4'($urandom);
            if (mode == 0) begin
                d = $urandom_range(0, 5);
                repeat (d) begin
                    bus.dec_ack = 1'($urandom_range(0, 1));
                    tick();
                    chk("busy_wait_busy", 32'(busy), 1);
                    chk("busy_wait_abort", 32'(abort), 0);
                end
                bus.dec_ack  = 1'b0;
                bus.dec_done = 1'b1;
                tick();
                bus.dec_done = 1'b0;
                chk("done_busy", 32'(busy), 0);
                chk("done_abort", 32'(abort), 0);
                model_done(exp_id, frame_exist);
            end else if (mode == 1) begin
                repeat (int'(TMO) - 1) tick();
                chk("pre_tmo_abort", 32'(abort), 0);
                chk("pre_tmo_busy", 32'(busy), 1);
                tick();
                chk("tmo_abort", 32'(abort), 1);
                chk("tmo_busy", 32'(busy), 0);
                tick();
                chk("tmo_abort_pulse", 32'(abort), 0);
                chk("tmo_idle_no_grant", 32'(bus.grant_valid), 0);
                m_starve[exp_id] = 0;
            end else begin
                repeat (int'(TMO) - 1) tick();
                bus.dec_done = 1'b1;
                tick();
                bus.dec_done = 1'b0;
                chk("coinc_abort", 32'(abort), 0);
                chk("coinc_busy", 32'(busy), 0);
                model_done(exp_id, frame_exist);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bus.dec_ready = 1'b1;
        bus.dec_ack   = 1'b0;
        bus.dec_done  = 1'b0;
        #3;
        do_reset();

        run_txn(4'b1010, 4'b0000, 4'b0000, 1, 0, 1'b0);
        run_txn(4'b1010, 4'b0000, 4'b0000, 3, 0, 1'b0);
        run_txn(4'b1010, 4'b0000, 4'b0000, 1, 0, 1'b0);

        do_reset();
        run_txn(4'b0001, 4'b0000, 4'b0100, 2, 0, 1'b0);

        run_txn(4'b1000, 4'b0000, 4'b0000, 3, 1, 1'b0);
        run_txn(4'b1000, 4'b0000, 4'b0000, 3, 2, 1'b0);
        run_txn(4'b1111, 4'b0000, 4'b0000, 0, 0, 1'b0);

        // Reset while a grant to port 2 is pending.
        set_flags(4'b0100, 4'b0000, 4'b0000);
        sched_en = 1'b1;
        tick();
        sched_en = 1'b0;
        chk("pre_rst_grant_id", 32'(bus.grant_id), 2);
        chk("pre_rst_grant_valid", 32'(bus.grant_valid), 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("async_rst_grant_valid", 32'(bus.grant_valid), 0);
        chk("async_rst_grant_id", 32'(bus.grant_id), 0);
        chk("async_rst_busy", 32'(busy), 0);
        tick();
        arst_n = 1'b1;
        model_reset();
        run_txn(4'b1111, 4'b0000, 4'b0000, 0, 0, 1'b0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1001, 4'b0000, 4'b1000, (i < 4) ? 3 : 0, 0, 1'b0);
        end

        bus.dec_ready = 1'b0;
        set_flags(4'b1111, 4'b0000, 4'b0000);
        sched_en = 1'b1;
        repeat (3) tick();
        sched_en = 1'b0;
        chk("dec_not_ready_no_grant", 32'(bus.grant_valid), 0);
        bus.dec_ready = 1'b1;

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            run_txn(4'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom),
                    -1, (r == 0) ? 1 : ((r == 1) ? 2 : 0), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_rx_sched.md
MAC_RX_SCHED -- requirements
Module: mac_rx_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of completed frames a waiting port may be bypassed before promotion (range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 16'd4095, meaning the maximum cycles in BUSY before abort.
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port arst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port sched_en, input, 1, enables new grants.
REQ-006 SHALL have port frame_exist, input, 4, per-PHY-FIFO complete-frame flag (clk domain).
REQ-007 SHALL have port fifo_half, input, 4, per-PHY-FIFO half flag (write-clock domain).
REQ-008 SHALL have port fifo_afull, input, 4, per-PHY-FIFO almost-full flag (write-clock domain).
REQ-009 SHALL have port dec_ready, input, 1, decoder idle and header/body FIFOs not full.
REQ-010 SHALL have port grant_valid, output, 1, grant offer to decoder.
REQ-011 SHALL have port grant_id, output, 2, granted PHY index.
REQ-012 SHALL have port dec_ack, input, 1, decoder accepted grant.
REQ-013 SHALL have port dec_done, input, 1, one-cycle pulse marking end of frame (delimiter consumed).
REQ-014 SHALL have port abort, output, 1, one-cycle pulse on timeout.
REQ-015 SHALL have port busy, output, 1, high in GRANT or BUSY.

Function
REQ-016 SHALL synchronise fifo_half and fifo_afull through 2-FF synchronisers before use; frame_exist SHALL be used directly.
REQ-017 SHALL classify port p by level: L3 = frame_exist[p] and starve_cnt[p]==STARVE_LIMIT; L2 = afull_s[p]; L1 = half_s[p]; L0 = frame_exist[p]; otherwise not eligible.
REQ-018 SHALL pick from the highest non-empty level, round-robin within the level starting at rr_ptr, then rr_ptr+1 and onward modulo 4.
REQ-019 SHALL implement states IDLE, GRANT, BUSY.
REQ-020 IDLE: if sched_en & dec_ready & any port eligible, SHALL register the winner into grant_id, assert grant_valid on the next cycle, and enter GRANT; otherwise SHALL stay in IDLE.
REQ-021 GRANT: SHALL hold grant_valid and grant_id stable until dec_ack; on dec_ack SHALL deassert grant_valid on the next cycle and enter BUSY.
REQ-022 GRANT SHALL NOT be withdrawn by sched_en going low or by flags changing.
REQ-023 BUSY: on dec_done SHALL set rr_ptr = grant_id+1 (mod 4), update the starvation counters, and enter IDLE.
REQ-024 Starvation update on dec_done: starve_cnt[grant_id] SHALL be set to 0; every other port with frame_exist=1 SHALL increment its 3-bit counter, saturating at STARVE_LIMIT; ports with frame_exist=0 SHALL clear their counters.
REQ-025 BUSY SHALL count cycles; when the count reaches TIMEOUT with no dec_done, SHALL pulse abort for one cycle, leave rr_ptr and the counters unchanged except starve_cnt[grant_id] set to 0, and enter IDLE.
REQ-026 If dec_done and timeout occur in the same cycle, dec_done SHALL take precedence and no abort SHALL be issued.
REQ-027 dec_ack outside GRANT and dec_done outside BUSY SHALL be ignored.
REQ-028 Minimum spacing between grants SHALL be 1 IDLE cycle after BUSY exit.

Reset
REQ-029 Asserting arst_n low in any state SHALL immediately force IDLE, grant_valid=0, grant_id=0, abort=0, busy=0, rr_ptr=0, all starve_cnt=0, and the timeout counter=0.
REQ-030 Synchroniser flops SHALL reset to 0.

Structure
REQ-031 Package mac_sched_pkg SHALL hold the state encodings, the level constants L0..L3, and the defaults STARVE_LIMIT and TIMEOUT.
REQ-032 The round-robin picker SHALL be the sub-module rr_pick4, which takes a 4-bit request vector and a 2-bit pointer and returns a valid flag and a 2-bit index; it SHALL be instantiated once on the selected level vector.
REQ-033 The existing vec_sync_2ff (WIDTH=4) SHALL be reused for both flag vectors.

Verification
REQ-034 Scenario: reset, frame_exist=4'b1010, dec_ready=1 -> grant_id=1; after ack/done the next grant_id=3, then 1.
REQ-035 Scenario: frame_exist=4'b0001, fifo_afull=4'b0100 held >=2 cycles -> grant_id=2 despite rr_ptr=0.
REQ-036 Scenario: port 3 has afull continuously, port 0 has only frame_exist, STARVE_LIMIT=4 -> after 4 completed frames on port 3, the 5th grant goes to port 0.
REQ-037 Scenario: grant accepted, dec_done withheld, TIMEOUT=20 -> abort pulses 20 cycles after entering BUSY, then state is IDLE with busy=0.
REQ-038 Scenario: dec_done and timeout in the same cycle -> abort=0, rr_ptr advances.
REQ-039 Scenario: arst_n low during GRANT with grant_id=2 -> grant_valid=0 and grant_id=0 asynchronously, rr_ptr=0 after release.
